// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pkg
//  Purpose  : Control bundle layout, ISA opcodes, FSM state encoding and
//             canned bundles shared by the ctrl_pipe slice.
//  Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    localparam int CW = 26;

    // Bundle bit offsets (valid in the LSB, err in the MSB)
    localparam int F_VALID     = 0;
    localparam int F_REG_WRITE = 1;
    localparam int F_DEST_SEL  = 2;
    localparam int F_PC_SEL    = 4;
    localparam int F_REG_JMP   = 5;
    localparam int F_MEM_EN    = 6;
    localparam int F_MEM_WR    = 7;
    localparam int F_ALU_CTRL  = 8;
    localparam int F_VAL2REG   = 13;
    localparam int F_ALU_SEL   = 14;
    localparam int F_IMM_SEL   = 15;
    localparam int F_HALT      = 18;
    localparam int F_LINK      = 19;
    localparam int F_SIIC      = 21;
    localparam int F_RTI       = 22;
    localparam int F_B_FLAG    = 23;
    localparam int F_J_FLAG    = 24;
    localparam int F_ERR       = 25;

    typedef struct packed {
        logic       err;
        logic       j_flag;
        logic       b_flag;
        logic       rti;
        logic       siic;
        logic [1:0] link;
        logic       halt;
        logic [2:0] imm_sel;
        logic       alu_sel;
        logic       val2reg;
        logic [4:0] alu_ctrl;
        logic       mem_wr;
        logic       mem_en;
        logic       reg_jmp;
        logic       pc_sel;
        logic [1:0] dest_sel;
        logic       reg_write;
        logic       valid;
    } ctrl_t;

    // Opcodes, instr[15:11]
    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_SIIC  = 5'b00010;
    localparam logic [4:0] OP_RTI   = 5'b00011;
    localparam logic [4:0] OP_J     = 5'b00100;
    localparam logic [4:0] OP_JR    = 5'b00101;
    localparam logic [4:0] OP_JAL   = 5'b00110;
    localparam logic [4:0] OP_JALR  = 5'b00111;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_ANDNI = 5'b01011;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_BNEZ  = 5'b01101;
    localparam logic [4:0] OP_BLTZ  = 5'b01110;
    localparam logic [4:0] OP_BGEZ  = 5'b01111;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_SLBI  = 5'b10010;
    localparam logic [4:0] OP_STU   = 5'b10011;
    localparam logic [4:0] OP_ROLI  = 5'b10100;
    localparam logic [4:0] OP_SLLI  = 5'b10101;
    localparam logic [4:0] OP_RORI  = 5'b10110;
    localparam logic [4:0] OP_SRLI  = 5'b10111;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_BTR   = 5'b11001;
    localparam logic [4:0] OP_SHIFT = 5'b11010;
    localparam logic [4:0] OP_ADD   = 5'b11011;
    localparam logic [4:0] OP_SEQ   = 5'b11100;
    localparam logic [4:0] OP_SLT   = 5'b11101;
    localparam logic [4:0] OP_SLE   = 5'b11110;
    localparam logic [4:0] OP_SCO   = 5'b11111;

    // dest_sel: which instruction field names the write-back register
    localparam logic [1:0] DEST_RD_I = 2'b00;  // instr[7:5]
    localparam logic [1:0] DEST_RD_R = 2'b01;  // instr[4:2]
    localparam logic [1:0] DEST_RS   = 2'b10;  // instr[10:8]
    localparam logic [1:0] DEST_R7   = 2'b11;

    localparam logic [2:0] IMM_ZEXT5  = 3'd0;
    localparam logic [2:0] IMM_SEXT5  = 3'd1;
    localparam logic [2:0] IMM_SEXT8  = 3'd2;
    localparam logic [2:0] IMM_ZEXT8  = 3'd3;
    localparam logic [2:0] IMM_SEXT11 = 3'd4;

    localparam logic [1:0] LINK_PC2 = 2'b01;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_HANDLER = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_HALTED  = 2'd3;

    localparam logic [CW-1:0] BUBBLE     = '0;
    localparam logic [CW-1:0] NOP_BUNDLE = 26'h000_0001;  // valid only
    localparam logic [CW-1:0] ERR_BUNDLE = 26'h200_0001;  // valid + err

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_decode
//  Purpose  : Combinational opcode -> control bundle table.
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] i_op,
    output ctrl_t          o_bundle
);

    always_comb begin
        o_bundle       = '0;
        o_bundle.valid = 1'b1;
        case (i_op)
            OP_HALT: o_bundle.halt = 1'b1;
            OP_NOP:  ;
            OP_SIIC: o_bundle.siic = 1'b1;
            OP_RTI:  o_bundle.rti  = 1'b1;
            OP_ADDI, OP_SUBI: begin
                o_bundle.reg_write = 1'b1;
                o_bundle.dest_sel  = DEST_RD_I;
                o_bundle.alu_sel   = 1'b1;
                o_bundle.imm_sel   = IMM_SEXT5;
                o_bundle.alu_ctrl  = 5'(i_op);
            end
            OP_XORI, OP_ANDNI, OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
                o_bundle.reg_write = 1'b1;
                o_bundle.dest_sel  = DEST_RD_I;
                o_bundle.alu_sel   = 1'b1;
                o_bundle.imm_sel   = IMM_ZEXT5;
                o_bundle.alu_ctrl  = 5'(i_op);
            end
            // Memory ops compute the address with the ADDI datapath
            OP_ST: begin
                o_bundle.mem_en   = 1'b1;
                o_bundle.mem_wr   = 1'b1;
                o_bundle.alu_sel  = 1'b1;
                o_bundle.imm_sel  = IMM_SEXT5;
                o_bundle.alu_ctrl = OP_ADDI;
            end
            OP_LD: begin
                o_bundle.reg_write = 1'b1;
                o_bundle.dest_sel  = DEST_RD_I;
                o_bundle.mem_en    = 1'b1;
                o_bundle.val2reg   = 1'b1;
                o_bundle.alu_sel   = 1'b1;
                o_bundle.imm_sel   = IMM_SEXT5;
                o_bundle.alu_ctrl  = OP_ADDI;
            end
            OP_STU: begin
                o_bundle.reg_write = 1'b1;
                o_bundle.dest_sel  = DEST_RS;
                o_bundle.mem_en    = 1'b1;
                o_bundle.mem_wr    = 1'b1;
                o_bundle.alu_sel   = 1'b1;
                o_bundle.imm_sel   = IMM_SEXT5;
                o_bundle.alu_ctrl  = OP_ADDI;
            end
            OP_BTR, OP_SHIFT, OP_ADD, OP_SEQ, OP_SLT, OP_SLE, OP_SCO: begin
                o_bundle.reg_write = 1'b1;
                o_bundle.dest_sel  = DEST_RD_R;
                o_bundle.alu_ctrl  = 5'(i_op);
            end
            OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: begin
                o_bundle.b_flag   = 1'b1;
                o_bundle.imm_sel  = IMM_SEXT8;
                o_bundle.alu_ctrl = 5'(i_op);
            end
            OP_LBI, OP_SLBI: begin
                o_bundle.reg_write = 1'b1;
                o_bundle.dest_sel  = DEST_RS;
                o_bundle.alu_sel   = 1'b1;
                o_bundle.imm_sel   = (i_op == OP_LBI) ? IMM_SEXT8 : IMM_ZEXT8;
                o_bundle.alu_ctrl  = 5'(i_op);
            end
            OP_J, OP_JAL: begin
                o_bundle.j_flag  = 1'b1;
                o_bundle.pc_sel  = 1'b1;
                o_bundle.imm_sel = IMM_SEXT11;
                if (i_op == OP_JAL) begin
                    o_bundle.reg_write = 1'b1;
                    o_bundle.dest_sel  = DEST_R7;
                    o_bundle.link      = LINK_PC2;
                end
            end
            OP_JR, OP_JALR: begin
                o_bundle.j_flag  = 1'b1;
                o_bundle.pc_sel  = 1'b1;
                o_bundle.reg_jmp = 1'b1;
                o_bundle.alu_sel = 1'b1;
                o_bundle.imm_sel = IMM_SEXT8;
                if (i_op == OP_JALR) begin
                    o_bundle.reg_write = 1'b1;
                    o_bundle.dest_sel  = DEST_R7;
                    o_bundle.link      = LINK_PC2;
                end
            end
            default: o_bundle.err = 1'b1;
        endcase
    end

endmodule : ctrl_decode
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pipe
//  Purpose  : Decodes the ID opcode and carries the control bundle through
//             DEPTH stage registers; sequences SIIC/RTI and HALT drain.
//             Optional counters enabled by `define CTRL_PERF_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int             OPW     = 5,
    parameter int             DEPTH   = 3,
    parameter int             PCW     = 16,
    parameter logic [PCW-1:0] EXC_VEC = 16'h0002
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPW-1:0]      op_id,
    input  logic                valid_id,
    input  logic [PCW-1:0]      pc2_id,
    input  logic                stall,
    input  logic                flush,
    output logic [DEPTH*CW-1:0] ctrl_stg,
    output logic                exc_redirect,
    output logic                rti_redirect,
    output logic [PCW-1:0]      exc_pc,
    output logic [PCW-1:0]      epc,
    output logic                halted,
    output logic [1:0]          fsm_state,
    output logic [31:0]         perf_retired,
    output logic [31:0]         perf_bubbles
);

    ctrl_t                      w_dec;
    logic [DEPTH-1:0][CW-1:0]   r_stg;
    logic [CW-1:0]              w_stg1_next;
    logic [1:0]                 r_state;
    logic [1:0]                 w_state_next;
    logic                       w_accept;
    logic                       w_take_exc;
    logic                       w_take_rti;
    logic                       w_drain_done;
    logic [PCW-1:0]             r_epc;
    logic                       r_exc_redirect;
    logic                       r_rti_redirect;

    ctrl_decode #(
        .OPW      (OPW)
    ) u_decode (
        .i_op     (op_id),
        .o_bundle (w_dec)
    );

    assign w_accept     = valid_id & ~stall & ~flush &
                          ((r_state == ST_RUN) | (r_state == ST_HANDLER));
    assign w_drain_done = r_stg[DEPTH-1][F_VALID] & r_stg[DEPTH-1][F_HALT];

    always_comb begin
        w_state_next = r_state;
        w_stg1_next  = BUBBLE;
        w_take_exc   = 1'b0;
        w_take_rti   = 1'b0;
        case (r_state)
            ST_RUN, ST_HANDLER: begin
                if (w_accept) begin
                    w_stg1_next = w_dec;
                    if (w_dec.halt) begin
                        w_state_next = ST_DRAIN;
                    end else if (w_dec.siic) begin
                        if (r_state == ST_RUN) begin
                            w_take_exc   = 1'b1;
                            w_state_next = ST_HANDLER;
                        end else begin
                            // SIIC inside the handler has no return path
                            w_stg1_next = ERR_BUNDLE;
                        end
                    end else if (w_dec.rti) begin
                        if (r_state == ST_HANDLER) begin
                            w_take_rti   = 1'b1;
                            w_state_next = ST_RUN;
                        end else begin
                            w_stg1_next = NOP_BUNDLE;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (w_drain_done) begin
                    w_state_next = ST_HALTED;
                end
            end
            default: w_state_next = ST_HALTED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg <= '0;
        end else begin
            r_stg[0] <= w_stg1_next;
            for (int k = 1; k < DEPTH; k++) begin
                r_stg[k] <= r_stg[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_RUN;
            r_epc          <= '0;
            r_exc_redirect <= 1'b0;
            r_rti_redirect <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_exc_redirect <= w_take_exc;
            r_rti_redirect <= w_take_rti;
            if (w_take_exc) begin
                r_epc <= pc2_id;
            end
        end
    end

    assign ctrl_stg     = r_stg;
    assign exc_redirect = r_exc_redirect;
    assign rti_redirect = r_rti_redirect;
    assign exc_pc       = r_exc_redirect ? EXC_VEC :
                          (r_rti_redirect ? r_epc : '0);
    assign epc          = r_epc;
    assign halted       = (r_state == ST_HALTED);
    assign fsm_state    = r_state;

`ifdef CTRL_PERF_EN
    logic [31:0] r_perf_retired;
    logic [31:0] r_perf_bubbles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_retired <= '0;
            r_perf_bubbles <= '0;
        end else if (r_state != ST_HALTED) begin
            if (r_stg[DEPTH-1][F_VALID]) begin
                r_perf_retired <= r_perf_retired + 32'd1;
            end
            if (!r_stg[0][F_VALID]) begin
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
            end
        end
    end

    assign perf_retired = r_perf_retired;
    assign perf_bubbles = r_perf_bubbles;
`else
    assign perf_retired = '0;
    assign perf_bubbles = '0;
`endif

endmodule : ctrl_pipe
`default_nettype wire
